hazard_stall: RTL and testbench

Pipeline interlock for the 5-stage MIPS core, the counterpart of the forwarding unit. Forwarding resolves data hazards by bypass. This block covers the cases bypass cannot: load-use, and a beq in ID whose operand is still in flight. For those it freezes PC and IF/ID and injects a bubble into ID/EX. It also flushes IF/ID on a taken beq or a jump, and keeps a stall-cycle performance counter and a sticky interlock-error flag.

---
 rtl/core_pkg.sv | 25 ++
 rtl/hazard_match.sv | 53 +++++
 rtl/hazard_stall.sv | 111 +++++++++++
 tb/tb_hazard_stall.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: opcode constants and the interlock FSM state type.
// Imported by the hazard unit, the forwarding unit and the decoder.
package core_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    typedef enum logic {
        HZ_IDLE = 1'b0,
        HZ_HOLD = 1'b1
    } hz_state_t;

    // A used, non-zero source register equal to a destination register.
    function automatic logic reg_hit(
        input logic [4:0] src,
        input logic [4:0] dst,
        input logic       used
    );
        return used && (src != 5'd0) && (src == dst);
    endfunction

endpackage

// File: rtl/hazard_match.sv
// Hazard detection: how many stall cycles the ID instruction needs.
// In: op, rs, rt, EXE/MEM destination fields. Out: need[1:0] (0, 1 or 2).
module hazard_match
    import core_pkg::*;
(
    input  logic [5:0] op,
    input  logic [4:0] rs,
    input  logic [4:0] rt,
    input  logic [4:0] EXE_num_write,
    input  logic       EXE_reg_write,
    input  logic       EXE_mem_read,
    input  logic [4:0] MEM_num_write,
    input  logic       MEM_mem_read,
    output logic [1:0] need
);

    logic use_rs;
    logic use_rt;
    logic is_beq;
    logic m_ex;
    logic m_exl;
    logic m_meml;

    assign use_rs = (op != OP_J);
    assign use_rt = (op == OP_RTYPE) || (op == OP_BEQ) || (op == OP_SW);
    assign is_beq = (op == OP_BEQ);

    assign m_ex = EXE_reg_write &&
                  (reg_hit(rs, EXE_num_write, use_rs) ||
                   reg_hit(rt, EXE_num_write, use_rt));

    assign m_exl = m_ex && EXE_mem_read;

    assign m_meml = MEM_mem_read &&
                    (reg_hit(rs, MEM_num_write, use_rs) ||
                     reg_hit(rt, MEM_num_write, use_rt));

    // beq compares in ID, so it also waits for ALU results and for a load
    // still in MEM; everything else only waits on a load in EXE.
    always_comb begin
        need = 2'd0;
        if (is_beq) begin
            if (m_exl) begin
                need = 2'd2;
            end else if (m_ex || m_meml) begin
                need = 2'd1;
            end
        end else if (m_exl) begin
            need = 2'd1;
        end
    end

endmodule

// File: rtl/hazard_stall.sv
// Pipeline interlock: stalls PC/IF-ID, bubbles ID/EX, flushes IF/ID on
// taken beq or j. Ports: clock, resetn, ID/EXE/MEM fields, branch_taken;
// outputs pc_write, ifid_write, ifid_flush, idex_bubble, stall_cycles,
// hazard_err (sticky after 3 consecutive stall cycles).
module hazard_stall
    import core_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [5:0]       op,
    input  logic [4:0]       rs,
    input  logic [4:0]       rt,
    input  logic [4:0]       EXE_num_write,
    input  logic             EXE_reg_write,
    input  logic             EXE_mem_read,
    input  logic [4:0]       MEM_num_write,
    input  logic             MEM_mem_read,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             hazard_err
);

    hz_state_t  state;
    hz_state_t  state_nxt;
    logic [1:0] need;
    logic       stall;
    logic [1:0] consec;

    hazard_match u_match (
        .op            (op),
        .rs            (rs),
        .rt            (rt),
        .EXE_num_write (EXE_num_write),
        .EXE_reg_write (EXE_reg_write),
        .EXE_mem_read  (EXE_mem_read),
        .MEM_num_write (MEM_num_write),
        .MEM_mem_read  (MEM_mem_read),
        .need          (need)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= HZ_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // HOLD is the second cycle of a beq-after-lw stall; inputs are ignored
    // there because the load has moved to MEM and need would read 1 again.
    always_comb begin
        state_nxt   = state;
        stall       = 1'b0;
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        unique case (state)
            HZ_IDLE: begin
                stall = (need != 2'd0);
                if (need == 2'd2) begin
                    state_nxt = HZ_HOLD;
                end
            end
            HZ_HOLD: begin
                stall     = 1'b1;
                state_nxt = HZ_IDLE;
            end
            default: state_nxt = HZ_IDLE;
        endcase
        if (stall) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
        end else begin
            ifid_flush = ((op == OP_BEQ) && branch_taken) || (op == OP_J);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    // A legal stall run is at most 2 cycles; a third flags a stuck interlock.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            consec     <= 2'd0;
            hazard_err <= 1'b0;
        end else if (stall) begin
            if (consec != 2'd3) begin
                consec <= consec + 2'd1;
            end
            if (consec >= 2'd2) begin
                hazard_err <= 1'b1;
            end
        end else begin
            consec <= 2'd0;
        end
    end

endmodule

// File: tb/tb_hazard_stall.sv
// Scoreboard bench for hazard_stall: directed vectors push expected
// outputs; a monitor pops and compares on the falling clock edge.
module tb_hazard_stall;

    localparam int CW = 3;

    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] J    = 6'b000010;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] SW   = 6'b101011;

    typedef struct {
        int          id;
        logic        pcw;
        logic        flush;
        logic [CW-1:0] cnt;
        logic        err;
    } exp_t;

    logic          clock;
    logic          resetn;
    logic [5:0]    op;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    EXE_num_write;
    logic          EXE_reg_write;
    logic          EXE_mem_read;
    logic [4:0]    MEM_num_write;
    logic          MEM_mem_read;
    logic          branch_taken;
    logic          pc_write;
    logic          ifid_write;
    logic          ifid_flush;
    logic          idex_bubble;
    logic [CW-1:0] stall_cycles;
    logic          hazard_err;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   vid = 0;

    hazard_stall #(.CNT_W(CW)) dut (
        .clock         (clock),
        .resetn        (resetn),
        .op            (op),
        .rs            (rs),
        .rt            (rt),
        .EXE_num_write (EXE_num_write),
        .EXE_reg_write (EXE_reg_write),
        .EXE_mem_read  (EXE_mem_read),
        .MEM_num_write (MEM_num_write),
        .MEM_mem_read  (MEM_mem_read),
        .branch_taken  (branch_taken),
        .pc_write      (pc_write),
        .ifid_write    (ifid_write),
        .ifid_flush    (ifid_flush),
        .idex_bubble   (idex_bubble),
        .stall_cycles  (stall_cycles),
        .hazard_err    (hazard_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic issue(
        input logic       rst,
        input logic [5:0] o,
        input logic [4:0] s,
        input logic [4:0] t,
        input logic [4:0] en,
        input logic       ew,
        input logic       el,
        input logic [4:0] mn,
        input logic       ml,
        input logic       bt,
        input logic       e_pcw,
        input logic       e_flush,
        input int         e_cnt,
        input logic       e_err
    );
        exp_t e;
        @(posedge clock);
        #1;
        resetn        = rst;
        op            = o;
        rs            = s;
        rt            = t;
        EXE_num_write = en;
        EXE_reg_write = ew;
        EXE_mem_read  = el;
        MEM_num_write = mn;
        MEM_mem_read  = ml;
        branch_taken  = bt;
        e.id    = vid;
        e.pcw   = e_pcw;
        e.flush = e_flush;
        e.cnt   = CW'(e_cnt);
        e.err   = e_err;
        q.push_back(e);
        vid++;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (pc_write !== e.pcw || ifid_write !== e.pcw ||
                    idex_bubble !== ~e.pcw || ifid_flush !== e.flush ||
                    stall_cycles !== e.cnt || hazard_err !== e.err) begin
                    errors++;
                    $display("FAIL vec%0d: got pcw=%b ifw=%b bub=%b fl=%b cnt=%0d err=%b, want pcw=%b ifw=%b bub=%b fl=%b cnt=%0d err=%b",
                             e.id, pc_write, ifid_write, idex_bubble,
                             ifid_flush, stall_cycles, hazard_err,
                             e.pcw, e.pcw, ~e.pcw, e.flush, e.cnt, e.err);
                end
            end
        end
    end

    initial begin : stim
        int budget;
        resetn        = 1'b0;
        op            = RT;
        rs            = '0;
        rt            = '0;
        EXE_num_write = '0;
        EXE_reg_write = 1'b0;
        EXE_mem_read  = 1'b0;
        MEM_num_write = '0;
        MEM_mem_read  = 1'b0;
        branch_taken  = 1'b0;
        //    rst op    rs rt  en ew el  mn ml bt  pcw fl cnt err
        issue(0, RT,   1, 2,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0);
        // lw $5 in EXE, add uses $5: one stall
        issue(1, RT,   5, 6,  5, 1, 1,  0, 0, 0,  0,  0, 0, 0);
        issue(1, RT,   5, 6,  0, 0, 0,  5, 1, 0,  1,  0, 1, 0);
        // beq after lw $5: two stalls then taken flush
        issue(1, BEQ,  5, 6,  5, 1, 1,  0, 0, 1,  0,  0, 1, 0);
        issue(1, BEQ,  5, 6,  0, 0, 0,  5, 1, 1,  0,  0, 2, 0);
        issue(1, BEQ,  5, 6,  0, 0, 0,  0, 0, 1,  1,  1, 3, 0);
        // beq rt=7 after ALU op writing $7: one stall, not taken
        issue(1, BEQ,  1, 7,  7, 1, 0,  0, 0, 0,  0,  0, 3, 0);
        issue(1, BEQ,  1, 7,  0, 0, 0,  7, 0, 0,  1,  0, 4, 0);
        // $0 never matches; j ignores rs and flushes; addi ignores rt
        issue(1, RT,   0, 0,  0, 1, 1,  0, 0, 0,  1,  0, 4, 0);
        issue(1, J,    5, 5,  5, 1, 1,  0, 0, 0,  1,  1, 4, 0);
        issue(1, ADDI, 9, 5,  5, 1, 1,  0, 0, 0,  1,  0, 4, 0);
        // stuck load match: err on third stall, counter saturates at 7
        issue(1, SW,   1, 5,  5, 1, 1,  0, 0, 0,  0,  0, 4, 0);
        issue(1, SW,   1, 5,  5, 1, 1,  0, 0, 0,  0,  0, 5, 0);
        issue(1, SW,   1, 5,  5, 1, 1,  0, 0, 0,  0,  0, 6, 0);
        issue(1, SW,   1, 5,  5, 1, 1,  0, 0, 0,  0,  0, 7, 1);
        issue(1, RT,   1, 2,  0, 0, 0,  0, 0, 1,  1,  0, 7, 1);
        // enter HOLD, then reset while in HOLD
        issue(1, BEQ,  3, 4,  3, 1, 1,  0, 0, 0,  0,  0, 7, 1);
        issue(0, RT,   1, 2,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0);
        issue(1, RT,   1, 2,  0, 0, 0,  0, 0, 0,  1,  0, 0, 0);
        // beq with a load in MEM: one stall, then taken flush
        issue(1, BEQ,  4, 6,  0, 0, 0,  4, 1, 1,  0,  0, 0, 0);
        issue(1, BEQ,  4, 6,  0, 0, 0,  0, 0, 1,  1,  1, 1, 0);
        budget = 0;
        while (q.size() > 0 && budget < 20) begin
            @(posedge clock);
            budget++;
        end
        if (q.size() > 0) begin
            errors++;
            checks++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        @(posedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
